id_hazard_stage: RTL
====================

ID_HAZARD_STAGE -- requirements
Module: id_hazard_stage

Interface
Parameters:
REQ-001 The block SHALL accept parameter DW, default 32, meaning the data width of registers and bypass paths.
REQ-002 The block SHALL accept parameter NREG, default 32, meaning the register count, a power of two ≥ 2.
REQ-003 The block SHALL accept parameter MD_LAT, default 5, meaning the mult/div busy cycles, range 1..255.
REQ-004 The block SHALL derive localparam AW = clog2(NREG), meaning the register address width.

Ports, name direction width meaning:
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 valid_id, branch_id, use_rs_id, use_rt_id  in  1 each  ID slot valid; branch compares in ID; rs read; rt read.
REQ-008 rs_id, rt_id, dest_id  in  AW each  source and destination register addresses.
REQ-009 regwrite_id, load_id, md_start_id, md_use_id  in  1 each  writes GPR; is load; starts mult/div; reads HI/LO.
REQ-010 mem_dest  in  AW; mem_regwrite, mem_load  in  1; mem_data  in  DW  MEM-stage producer.
REQ-011 wb_dest  in  AW; wb_we  in  1; wb_data  in  DW  WB write port.
REQ-012 flush  in  1  squash the ID slot.
REQ-013 stall  out  1  hold PC and IF/ID.
REQ-014 ex_valid, ex_regwrite, ex_load  out  1; ex_rd1, ex_rd2  out  DW; ex_dest  out  AW  ID/EX register.
REQ-015 op_a, op_b  out  DW  forwarded ID operands; cmp_eq  out  1  op_a==op_b.
REQ-016 md_busy  out  1  mult/div in progress.

Function
REQ-017 The register file SHALL hold NREG x DW; register 0 SHALL always read 0 and ignore writes.
REQ-018 A write with wb_we=1 and wb_dest!=0 SHALL update the file at the rising edge.
REQ-019 op_a/op_b SHALL be selected, in priority order: address 0 -> 0; MEM match (mem_regwrite, !mem_load, mem_dest==addr) -> mem_data; WB match (wb_we, wb_dest==addr) -> wb_data; else file contents.
REQ-020 The WB bypass SHALL provide same-cycle write-through.
REQ-021 A "hit on X" SHALL mean: X_dest!=0 and ((use_rs_id and X_dest==rs_id) or (use_rt_id and X_dest==rt_id)).
REQ-022 stall SHALL be asserted only when valid_id=1 and any of the following holds:
- (a) load-use: ex_valid, ex_load, and a hit on ex.
- (b) branch-EX: branch_id, ex_valid, ex_regwrite, and a hit on ex.
- (c) branch-MEM-load: branch_id, mem_load, and a hit on mem.
- (d) (md_use_id or md_start_id) with md_busy=1.
REQ-023 stall SHALL be combinational with zero latency.
REQ-024 At each edge, the ID/EX register SHALL behave as follows:
- If flush=1 or stall=1, it SHALL load a bubble: ex_valid=0, ex_regwrite=0, ex_load=0, ex_dest=0; ex_rd1/ex_rd2 don't-care.
- Otherwise it SHALL load ex_valid=valid_id, ex_rd1=op_a, ex_rd2=op_b, ex_dest=dest_id, ex_regwrite=regwrite_id&valid_id, ex_load=load_id&valid_id.
REQ-025 flush SHALL take priority over stall, and a bubble SHALL be inserted once per stalled cycle.
REQ-026 The mult/div counter md_cnt (8 bit) SHALL behave as follows:
- It SHALL load MD_LAT on an accepted md_start_id (valid_id, !stall, !flush).
- Otherwise it SHALL decrement when nonzero.
- md_busy SHALL equal (md_cnt!=0).
REQ-027 An md_start_id issued while busy SHALL stall until the counter reaches 0, then be accepted.
REQ-028 A load in MEM matching a non-branch consumer SHALL NOT stall; the stale value is captured in ID/EX and EX-stage forwarding resolves it.

Reset
REQ-029 While rst_n=0, the following SHALL be asynchronously cleared: ex_valid, ex_regwrite, ex_load, ex_dest, ex_rd1, ex_rd2, md_cnt; md_busy SHALL be 0.
REQ-030 While rst_n=0, all register-file entries SHALL be cleared to 0.
REQ-031 Reset asserted mid mult/div SHALL abort the operation (md_busy=0 immediately).
REQ-032 Outputs SHALL resume normal updates at the first rising edge after rst_n rises.

Verification
REQ-033 Scenario write-through: wb_we=1, wb_dest=5, wb_data=0xDEADBEEF, rs_id=5, use_rs_id=1 -> op_a=0xDEADBEEF in the same cycle; ex_rd1=0xDEADBEEF after the edge.
REQ-034 Scenario load-use: EX holds a load (ex_dest=8); ID uses rt=8 -> stall=1 for exactly 1 cycle, one bubble (ex_valid=0), then the instruction issues with stall=0.
REQ-035 Scenario branch stalls: EX has an ALU write to r3 and ID has branch_id=1 on rs=3 -> stall for 1 cycle; then MEM forwards mem_data=7, op_a=7, and cmp_eq=1 against r_rt=7.
REQ-036 Scenario mult/div: md_start accepted at cycle 0 with MD_LAT=5 -> md_busy high for cycles 1-5; md_use_id at cycle 2 -> stall through cycle 5 and issue at cycle 6.
REQ-037 Scenario priority: flush=1 and stall=1 together -> bubble loaded and md_start not accepted. Separately, rs_id=0 with MEM/WB targeting 0 -> op_a=0.
REQ-038 Scenario reset: rst_n driven low mid-operation with md_busy=1 -> md_busy=0 and ex_valid=0 without a clock edge; all reads return 0 after release.

Source files
------------

// File: rtl/id_hazard_if.sv
// ID-stage bundle: decode slot, MEM/WB producers, WB write port, and ID/EX outputs.
// slave = hazard stage side, master = pipeline/driver side.
interface id_hazard_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          valid_id;
  logic          branch_id;
  logic          use_rs_id;
  logic          use_rt_id;
  logic [AW-1:0] rs_id;
  logic [AW-1:0] rt_id;
  logic [AW-1:0] dest_id;
  logic          regwrite_id;
  logic          load_id;
  logic          md_start_id;
  logic          md_use_id;
  logic [AW-1:0] mem_dest;
  logic          mem_regwrite;
  logic          mem_load;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] wb_dest;
  logic          wb_we;
  logic [DW-1:0] wb_data;
  logic          flush;
  logic          stall;
  logic          ex_valid;
  logic          ex_regwrite;
  logic          ex_load;
  logic [DW-1:0] ex_rd1;
  logic [DW-1:0] ex_rd2;
  logic [AW-1:0] ex_dest;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          cmp_eq;
  logic          md_busy;

  modport slave (
    input  valid_id, branch_id, use_rs_id, use_rt_id, rs_id, rt_id, dest_id,
           regwrite_id, load_id, md_start_id, md_use_id,
           mem_dest, mem_regwrite, mem_load, mem_data,
           wb_dest, wb_we, wb_data, flush,
    output stall, ex_valid, ex_regwrite, ex_load, ex_rd1, ex_rd2, ex_dest,
           op_a, op_b, cmp_eq, md_busy
  );

  modport master (
    output valid_id, branch_id, use_rs_id, use_rt_id, rs_id, rt_id, dest_id,
           regwrite_id, load_id, md_start_id, md_use_id,
           mem_dest, mem_regwrite, mem_load, mem_data,
           wb_dest, wb_we, wb_data, flush,
    input  stall, ex_valid, ex_regwrite, ex_load, ex_rd1, ex_rd2, ex_dest,
           op_a, op_b, cmp_eq, md_busy
  );
endinterface

// File: rtl/id_hazard_stage.sv
// Decode stage: register file with MEM/WB bypass, hazard detection (load-use,
// branch-in-ID, mult/div busy) and the ID/EX pipeline register.
module id_hazard_stage #(
  parameter int DW     = 32,
  parameter int NREG   = 32,
  parameter int MD_LAT = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_hazard_if.slave   bus
);
  localparam int          AW      = $clog2(NREG);
  localparam int unsigned NR      = NREG;
  localparam logic [7:0]  MD_INIT = 8'(MD_LAT);

  logic [DW-1:0] r_rf [NREG];
  logic          r_ex_valid;
  logic          r_ex_regwrite;
  logic          r_ex_load;
  logic [AW-1:0] r_ex_dest;
  logic [DW-1:0] r_ex_rd1;
  logic [DW-1:0] r_ex_rd2;
  logic [7:0]    r_md_cnt;

  logic          w_md_busy;
  logic          w_hit_ex;
  logic          w_hit_mem;
  logic          w_stall;
  logic          w_md_accept;
  logic          w_mem_fwd;
  logic [DW-1:0] w_op_a;
  logic [DW-1:0] w_op_b;

  // Bypass priority: r0, then MEM (non-load), then WB write-through, then file.
  function automatic logic [DW-1:0] fwd(
    input logic [AW-1:0] a,    input logic [DW-1:0] rf_q,
    input logic          m_ok, input logic [AW-1:0] m_dst, input logic [DW-1:0] m_dat,
    input logic          w_ok, input logic [AW-1:0] w_dst, input logic [DW-1:0] w_dat
  );
    if (a == '0)                return '0;
    if (m_ok && (m_dst == a))   return m_dat;
    if (w_ok && (w_dst == a))   return w_dat;
    return rf_q;
  endfunction

  assign w_mem_fwd = bus.mem_regwrite && !bus.mem_load;

  always_comb begin
    w_op_a = fwd(bus.rs_id, r_rf[bus.rs_id], w_mem_fwd, bus.mem_dest, bus.mem_data,
                 bus.wb_we, bus.wb_dest, bus.wb_data);
    w_op_b = fwd(bus.rt_id, r_rf[bus.rt_id], w_mem_fwd, bus.mem_dest, bus.mem_data,
                 bus.wb_we, bus.wb_dest, bus.wb_data);
  end

  assign w_hit_ex  = (r_ex_dest != '0) &&
                     ((bus.use_rs_id && (r_ex_dest == bus.rs_id)) ||
                      (bus.use_rt_id && (r_ex_dest == bus.rt_id)));
  assign w_hit_mem = (bus.mem_dest != '0) &&
                     ((bus.use_rs_id && (bus.mem_dest == bus.rs_id)) ||
                      (bus.use_rt_id && (bus.mem_dest == bus.rt_id)));

  assign w_md_busy = (r_md_cnt != '0);

  assign w_stall = bus.valid_id && (
                     (r_ex_valid && r_ex_load && w_hit_ex) ||
                     (bus.branch_id && r_ex_valid && r_ex_regwrite && w_hit_ex) ||
                     (bus.branch_id && bus.mem_load && w_hit_mem) ||
                     ((bus.md_use_id || bus.md_start_id) && w_md_busy));

  assign w_md_accept = bus.valid_id && bus.md_start_id && !w_stall && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NR; i++) r_rf[i] <= '0;
    end else if (bus.wb_we && (bus.wb_dest != '0)) begin
      r_rf[bus.wb_dest] <= bus.wb_data;
    end
  end

  // Bubble leaves rd1/rd2 holding their previous contents; they are don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_load     <= 1'b0;
      r_ex_dest     <= '0;
      r_ex_rd1      <= '0;
      r_ex_rd2      <= '0;
    end else if (bus.flush || w_stall) begin
      r_ex_valid    <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_load     <= 1'b0;
      r_ex_dest     <= '0;
    end else begin
      r_ex_valid    <= bus.valid_id;
      r_ex_regwrite <= bus.regwrite_id && bus.valid_id;
      r_ex_load     <= bus.load_id && bus.valid_id;
      r_ex_dest     <= bus.dest_id;
      r_ex_rd1      <= w_op_a;
      r_ex_rd2      <= w_op_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_md_cnt <= '0;
    else if (w_md_accept) r_md_cnt <= MD_INIT;
    else if (w_md_busy)   r_md_cnt <= r_md_cnt - 8'd1;
  end

  assign bus.stall       = w_stall;
  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_regwrite = r_ex_regwrite;
  assign bus.ex_load     = r_ex_load;
  assign bus.ex_dest     = r_ex_dest;
  assign bus.ex_rd1      = r_ex_rd1;
  assign bus.ex_rd2      = r_ex_rd2;
  assign bus.op_a        = w_op_a;
  assign bus.op_b        = w_op_b;
  assign bus.cmp_eq      = (w_op_a == w_op_b);
  assign bus.md_busy     = w_md_busy;
endmodule
